fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO: next generation of the team's 8-bit FIFO, generalised in width and depth.

---
 rtl/fifo_sync_param.sv | 147 ++++++++++++++
 tb/tb_fifo_sync_param.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Parametrised single-clock FIFO with programmable almost-full/almost-empty
//   thresholds, an occupancy counter, sticky overflow/underflow flags, a
//   synchronous flush and an optional first-word-fall-through read mode.
//
// Parameters
//   DATA_WIDTH  data word width in bits
//   DEPTH       number of entries (power of 2, >= 4)
//   AF_LEVEL    f_almost_full when f_count >= AF_LEVEL
//   AE_LEVEL    f_almost_empty when f_count <= AE_LEVEL
//   FWFT        0: registered read, data one cycle after enable_rd
//               1: head word presented on data_out while not empty
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   data_in         write data
//   enable_wr       write request
//   enable_rd       read request (FWFT=1: pop of the presented head word)
//   flush           synchronous clear of contents and sticky flags
//   data_out        read data
//   f_count         occupancy, 0..DEPTH
//   f_empty         f_count == 0
//   f_full          f_count == DEPTH
//   f_almost_full   f_count >= AF_LEVEL
//   f_almost_empty  f_count <= AE_LEVEL
//   f_overflow      sticky: a write was rejected
//   f_underflow     sticky: a read was rejected
module fifo_sync_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = 12,
    parameter int unsigned AE_LEVEL   = 4,
    parameter bit          FWFT       = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     enable_wr,
    input  logic                     enable_rd,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [$clog2(DEPTH):0]   f_count,
    output logic                     f_empty,
    output logic                     f_full,
    output logic                     f_almost_full,
    output logic                     f_almost_empty,
    output logic                     f_overflow,
    output logic                     f_underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic rd_ok;
    logic wr_ok;
    logic wr_reject;
    logic rd_reject;

    // Level flags are pure decodes of the registered count.
    assign f_count        = count;
    assign f_empty        = (count == '0);
    assign f_full         = (count == CNT_FULL);
    assign f_almost_full  = (count >= CNT_AF);
    assign f_almost_empty = (count <= CNT_AE);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write when a read is accepted alongside it. There is no empty bypass:
    // a read on an empty FIFO is rejected even if a write arrives with it.
    assign rd_ok     = enable_rd & ~f_empty;
    assign wr_ok     = enable_wr & (~f_full | rd_ok);
    assign wr_reject = enable_wr & ~wr_ok;
    assign rd_reject = enable_rd & ~rd_ok;

    // Storage: no reset, contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and sticky flags. Flush outranks both requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            f_overflow  <= 1'b0;
            f_underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            f_overflow  <= 1'b0;
            f_underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
            if (wr_reject) begin
                f_overflow <= 1'b1;
            end
            if (rd_reject) begin
                f_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is shown directly from storage; zero while empty so
            // the output matches its reset value.
            assign data_out = f_empty ? '0 : mem[rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                end else if (rd_ok && !flush) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
//   Directed bench for fifo_sync_param with DEPTH=8, AF_LEVEL=6, AE_LEVEL=2,
//   DATA_WIDTH=8. One instance uses the registered read path, a second one
//   uses first-word-fall-through.
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       reset;

    // registered-read instance
    logic [7:0] data_in;
    logic       enable_wr;
    logic       enable_rd;
    logic       flush;
    logic [7:0] data_out;
    logic [3:0] f_count;
    logic       f_empty, f_full, f_almost_full, f_almost_empty;
    logic       f_overflow, f_underflow;

    // FWFT instance
    logic [7:0] f2_data_in;
    logic       f2_enable_wr;
    logic       f2_enable_rd;
    logic       f2_flush;
    logic [7:0] f2_data_out;
    logic [3:0] f2_count;
    logic       f2_empty, f2_full, f2_almost_full, f2_almost_empty;
    logic       f2_overflow, f2_underflow;

    int checks = 0;
    int errors = 0;

    // {count, empty, full, almost_full, almost_empty, overflow, underflow}
    logic [9:0] st;
    logic [9:0] st2;
    assign st  = {f_count, f_empty, f_full, f_almost_full, f_almost_empty,
                  f_overflow, f_underflow};
    assign st2 = {f2_count, f2_empty, f2_full, f2_almost_full, f2_almost_empty,
                  f2_overflow, f2_underflow};

    fifo_sync_param #(
        .DATA_WIDTH(8),
        .DEPTH(8),
        .AF_LEVEL(6),
        .AE_LEVEL(2),
        .FWFT(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .enable_wr(enable_wr),
        .enable_rd(enable_rd),
        .flush(flush),
        .data_out(data_out),
        .f_count(f_count),
        .f_empty(f_empty),
        .f_full(f_full),
        .f_almost_full(f_almost_full),
        .f_almost_empty(f_almost_empty),
        .f_overflow(f_overflow),
        .f_underflow(f_underflow)
    );

    fifo_sync_param #(
        .DATA_WIDTH(8),
        .DEPTH(8),
        .AF_LEVEL(6),
        .AE_LEVEL(2),
        .FWFT(1'b1)
    ) dut_fwft (
        .clk(clk),
        .reset(reset),
        .data_in(f2_data_in),
        .enable_wr(f2_enable_wr),
        .enable_rd(f2_enable_rd),
        .flush(f2_flush),
        .data_out(f2_data_out),
        .f_count(f2_count),
        .f_empty(f2_empty),
        .f_full(f2_full),
        .f_almost_full(f2_almost_full),
        .f_almost_empty(f2_almost_empty),
        .f_overflow(f2_overflow),
        .f_underflow(f2_underflow)
    );

    always #5 clk = ~clk;

    // Expected status word for DEPTH=8, AF=6, AE=2.
    function automatic logic [9:0] exp_st(input int c, input logic of, input logic uf);
        logic [3:0] cw;
        cw = 4'(c);
        return {cw, (c == 0), (c == 8), (c >= 6), (c <= 2), of, uf};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable_wr    = 1'b0;
        enable_rd    = 1'b0;
        flush        = 1'b0;
        f2_enable_wr = 1'b0;
        f2_enable_rd = 1'b0;
        f2_flush     = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        data_in    = 8'h00;
        f2_data_in = 8'h00;
        reset      = 1'b1;
        #12;
        checks++;
        if (st !== exp_st(0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_status: got %b expected %b", st, exp_st(0, 1'b0, 1'b0));
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_out: got %h expected 00", data_out);
        end
        checks++;
        if (st2 !== exp_st(0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_status_fwft: got %b expected %b", st2, exp_st(0, 1'b0, 1'b0));
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] words [8];
        words = '{8'h0A, 8'h10, 8'h41, 8'h13, 8'hAA, 8'hBB, 8'hFF, 8'h07};
        for (int i = 0; i < 8; i++) begin
            enable_wr = 1'b1;
            data_in   = words[i];
            tick();
            checks++;
            if (st !== exp_st(i + 1, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL fill_status[%0d]: got %b expected %b", i, st, exp_st(i + 1, 1'b0, 1'b0));
            end
        end
        data_in = 8'h08;
        tick();
        enable_wr = 1'b0;
        checks++;
        if (st !== exp_st(8, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL fill_overflow: got %b expected %b", st, exp_st(8, 1'b1, 1'b0));
        end
    endtask

    task automatic test_drain();
        logic [7:0] words [8];
        words = '{8'h0A, 8'h10, 8'h41, 8'h13, 8'hAA, 8'hBB, 8'hFF, 8'h07};
        for (int i = 0; i < 8; i++) begin
            enable_rd = 1'b1;
            tick();
            checks++;
            if (data_out !== words[i]) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, words[i]);
            end
            checks++;
            if (st !== exp_st(7 - i, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL drain_status[%0d]: got %b expected %b", i, st, exp_st(7 - i, 1'b1, 1'b0));
            end
        end
        tick();
        enable_rd = 1'b0;
        checks++;
        if (st !== exp_st(0, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL drain_underflow: got %b expected %b", st, exp_st(0, 1'b1, 1'b1));
        end
        checks++;
        if (data_out !== 8'h07) begin
            errors++;
            $display("FAIL drain_hold: got %h expected 07", data_out);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (st !== exp_st(0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL flush_clear_sticky: got %b expected %b", st, exp_st(0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            enable_wr = 1'b1;
            data_in   = 8'hA0 + 8'(i);
            tick();
        end
        checks++;
        if (st !== exp_st(8, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL b2b_full: got %b expected %b", st, exp_st(8, 1'b0, 1'b0));
        end
        enable_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'hB0 + 8'(i);
            tick();
            checks++;
            if (data_out !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", i, data_out, 8'hA0 + 8'(i));
            end
            checks++;
            if (st !== exp_st(8, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL b2b_status[%0d]: got %b expected %b", i, st, exp_st(8, 1'b0, 1'b0));
            end
        end
        enable_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 4) ? 8'hA4 + 8'(i) : 8'hB0 + 8'(i - 4);
            tick();
            checks++;
            if (data_out !== exp) begin
                errors++;
                $display("FAIL wrap_data[%0d]: got %h expected %h", i, data_out, exp);
            end
            checks++;
            if (st !== exp_st(7 - i, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL wrap_status[%0d]: got %b expected %b", i, st, exp_st(7 - i, 1'b0, 1'b0));
            end
        end
        enable_rd = 1'b0;
    endtask

    task automatic test_empty_rw();
        enable_wr = 1'b1;
        enable_rd = 1'b1;
        data_in   = 8'hBB;
        tick();
        enable_wr = 1'b0;
        enable_rd = 1'b0;
        checks++;
        if (st !== exp_st(1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL empty_rw_status: got %b expected %b", st, exp_st(1, 1'b0, 1'b1));
        end
        checks++;
        if (data_out !== 8'hB3) begin
            errors++;
            $display("FAIL empty_rw_hold: got %h expected b3", data_out);
        end
        enable_rd = 1'b1;
        tick();
        enable_rd = 1'b0;
        checks++;
        if (data_out !== 8'hBB) begin
            errors++;
            $display("FAIL empty_rw_read: got %h expected bb", data_out);
        end
        checks++;
        if (st !== exp_st(0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL empty_rw_after: got %b expected %b", st, exp_st(0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        enable_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'h51 + 8'(i);
            tick();
        end
        checks++;
        if (st !== exp_st(5, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL pre_reset_status: got %b expected %b", st, exp_st(5, 1'b0, 1'b1));
        end
        // Reset lands between edges while a write is still being requested.
        data_in = 8'h56;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (st !== exp_st(0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_status: got %b expected %b", st, exp_st(0, 1'b0, 1'b0));
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_data_out: got %h expected 00", data_out);
        end
        enable_wr = 1'b0;
        reset     = 1'b0;
        tick();
        checks++;
        if (st !== exp_st(0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL post_reset_status: got %b expected %b", st, exp_st(0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_flush();
        enable_rd = 1'b1;
        tick();
        enable_rd = 1'b0;
        enable_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'h61 + 8'(i);
            tick();
        end
        enable_wr = 1'b0;
        enable_rd = 1'b1;
        tick();
        checks++;
        if (data_out !== 8'h61) begin
            errors++;
            $display("FAIL pre_flush_data: got %h expected 61", data_out);
        end
        checks++;
        if (st !== exp_st(4, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL pre_flush_status: got %b expected %b", st, exp_st(4, 1'b0, 1'b1));
        end
        flush     = 1'b1;
        enable_wr = 1'b1;
        data_in   = 8'h77;
        tick();
        flush     = 1'b0;
        enable_wr = 1'b0;
        enable_rd = 1'b0;
        checks++;
        if (st !== exp_st(0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL flush_status: got %b expected %b", st, exp_st(0, 1'b0, 1'b0));
        end
        checks++;
        if (data_out !== 8'h61) begin
            errors++;
            $display("FAIL flush_data_hold: got %h expected 61", data_out);
        end
        tick();
        checks++;
        if (st !== exp_st(0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL flush_write_ignored: got %b expected %b", st, exp_st(0, 1'b0, 1'b0));
        end
        enable_wr = 1'b1;
        data_in   = 8'h78;
        tick();
        enable_wr = 1'b0;
        enable_rd = 1'b1;
        tick();
        enable_rd = 1'b0;
        checks++;
        if (data_out !== 8'h78) begin
            errors++;
            $display("FAIL post_flush_read: got %h expected 78", data_out);
        end
    endtask

    task automatic test_fwft();
        checks++;
        if (f2_data_out !== 8'h00) begin
            errors++;
            $display("FAIL fwft_empty_out: got %h expected 00", f2_data_out);
        end
        f2_enable_wr = 1'b1;
        f2_data_in   = 8'hBF;
        tick();
        f2_enable_wr = 1'b0;
        checks++;
        if (f2_data_out !== 8'hBF) begin
            errors++;
            $display("FAIL fwft_visible: got %h expected bf", f2_data_out);
        end
        checks++;
        if (st2 !== exp_st(1, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL fwft_status1: got %b expected %b", st2, exp_st(1, 1'b0, 1'b0));
        end
        tick();
        checks++;
        if (f2_data_out !== 8'hBF) begin
            errors++;
            $display("FAIL fwft_hold: got %h expected bf", f2_data_out);
        end
        f2_enable_wr = 1'b1;
        f2_data_in   = 8'hC3;
        tick();
        f2_enable_wr = 1'b0;
        checks++;
        if (f2_data_out !== 8'hBF) begin
            errors++;
            $display("FAIL fwft_head_stable: got %h expected bf", f2_data_out);
        end
        f2_enable_rd = 1'b1;
        tick();
        checks++;
        if (f2_data_out !== 8'hC3) begin
            errors++;
            $display("FAIL fwft_pop_next: got %h expected c3", f2_data_out);
        end
        tick();
        f2_enable_rd = 1'b0;
        checks++;
        if (st2 !== exp_st(0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL fwft_pop_empty: got %b expected %b", st2, exp_st(0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_empty_rw();
        test_reset_mid();
        test_flush();
        test_fwft();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
